// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster-scan generator for the VGA path. Produces the pixel coordinates
// (DrawX/DrawY), the active-high display enable (blank), the active-low
// hs/vs sync pulses (delayed SYNC_DELAY stages to line up with the
// renderers' registered RGB stage), and line/frame markers plus a wrapping
// completed-frame counter for game-logic timing.
//
// Optional feature macro: VGA_TIMING_PIXEL_CE_EN
//   When defined, adds input pix_ce. Counters, frame_count and the sync delay
//   line only advance on vga_clk edges with pix_ce=1; line_start/frame_start
//   are high for exactly one vga_clk cycle. When undefined, every edge is an
//   advance and the port does not exist.
//
// Ports:
//   vga_clk      in   pixel clock (only clock)
//   reset_n      in   synchronous, active-low reset
//   pix_ce       in   pixel clock enable (only with VGA_TIMING_PIXEL_CE_EN)
//   DrawX        out  horizontal position, 0..H_TOTAL-1
//   DrawY        out  vertical position, 0..V_TOTAL-1
//   blank        out  1 = visible pixel, 0 = blanking interval
//   hs           out  horizontal sync, active low, SYNC_DELAY stages late
//   vs           out  vertical sync, active low, SYNC_DELAY stages late
//   line_start   out  one-cycle pulse while DrawX==0
//   frame_start  out  one-cycle pulse while DrawX==0 and DrawY==0
//   frame_count  out  completed-frame counter, wraps at 256
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
`ifdef VGA_TIMING_PIXEL_CE_EN
  input  logic       pix_ce,
`endif
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Bounds are held at 11 bits so a window ending exactly at 1024 still
  // compares correctly against a 10-bit counter.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY must be in 0..3");
    end
  endgenerate

  // Advance qualifier: every edge by default, pix_ce-gated when enabled.
  logic adv;
`ifdef VGA_TIMING_PIXEL_CE_EN
  assign adv = pix_ce;
`else
  assign adv = 1'b1;
`endif

  // running is cleared by reset. The first advance after release loads
  // (0,0) together with its decoded flags instead of stepping the counters,
  // so the first post-reset cycle presents pixel (0,0) as visible with both
  // start markers set.
  logic       running;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       end_of_line;
  logic       end_of_frame;

  assign end_of_line  = ({1'b0, DrawX} == H_LAST);
  assign end_of_frame = end_of_line && ({1'b0, DrawY} == V_LAST);

  always_comb begin
    x_nxt = DrawX;
    y_nxt = DrawY;
    if (!running) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (end_of_line) begin
      x_nxt = '0;
      y_nxt = end_of_frame ? 10'd0 : DrawY + 10'd1;
    end else begin
      x_nxt = DrawX + 10'd1;
    end
  end

  // Flags are decoded from the next-state coordinates and registered with
  // them, so DrawX/DrawY/blank/line_start/frame_start agree in every cycle.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      running     <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (adv) begin
      running     <= 1'b1;
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank       <= ({1'b0, x_nxt} < H_VIS_W) && ({1'b0, y_nxt} < V_VIS_W);
      line_start  <= (x_nxt == 10'd0);
      frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
      if (running && end_of_frame) begin
        frame_count <= frame_count + 8'd1;
      end
    end else begin
      // Non-advance edge (pix_ce=0): markers drop so each pulse lasts one
      // vga_clk cycle; coordinates and blank hold.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  // Raw syncs decoded from the registered counters (active low).
  logic hsync_raw;
  logic vsync_raw;

  assign hsync_raw = !(({1'b0, DrawX} >= HS_START) && ({1'b0, DrawX} < HS_END));
  assign vsync_raw = !(({1'b0, DrawY} >= VS_START) && ({1'b0, DrawY} < VS_END));

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs = hsync_raw;
      assign vs = vsync_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;

      // Reset fills every stage with the inactive level so a reset taken
      // inside a sync window cannot leak a runt pulse afterwards.
      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else if (adv) begin
          hs_pipe[0] <= hsync_raw;
          vs_pipe[0] <= vsync_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign hs = hs_pipe[SYNC_DELAY-1];
      assign vs = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share vga_clk:
//   dut_a : default 640x480 timing, SYNC_DELAY=1
//   dut_b : default 640x480 timing, SYNC_DELAY=0 (same reset as dut_a)
//   dut_c : tiny 16x9 raster (8+2+3+3 / 4+1+2+2), SYNC_DELAY=2, own reset,
//           used for whole-frame, frame_count and mid-frame reset checks.
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic vga_clk;
  logic rst_ab_n;
  logic rst_c_n;
  logic pix_ce;

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // ---------------- DUT signals ----------------
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic       blank_a, hs_a, vs_a, ls_a, fs_a;
  logic       blank_b, hs_b, vs_b, ls_b, fs_b;
  logic       blank_c, hs_c, vs_c, ls_c, fs_c;
  logic [7:0] fc_a, fc_b, fc_c;

  vga_timing_gen #(.SYNC_DELAY(1)) dut_a (
    .vga_clk(vga_clk), .reset_n(rst_ab_n),
`ifdef VGA_TIMING_PIXEL_CE_EN
    .pix_ce(pix_ce),
`endif
    .DrawX(x_a), .DrawY(y_a), .blank(blank_a), .hs(hs_a), .vs(vs_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut_b (
    .vga_clk(vga_clk), .reset_n(rst_ab_n),
`ifdef VGA_TIMING_PIXEL_CE_EN
    .pix_ce(pix_ce),
`endif
    .DrawX(x_b), .DrawY(y_b), .blank(blank_b), .hs(hs_b), .vs(vs_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_DELAY(2)
  ) dut_c (
    .vga_clk(vga_clk), .reset_n(rst_c_n),
`ifdef VGA_TIMING_PIXEL_CE_EN
    .pix_ce(pix_ce),
`endif
    .DrawX(x_c), .DrawY(y_c), .blank(blank_c), .hs(hs_c), .vs(vs_c),
    .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int blank_cnt, hs_low_a, hs_low_b, vs_low_ab;
    int fall_a, rise_a, fall_b, rise_b;
    logic prev_a, prev_b;
    int blank_c_cnt, blank_vbl, vs_low_c, fs_cnt, ls_cnt, vs_fall_x, vs_fall_y;
    logic prev_vs;
    int first_hs;

    pix_ce   = 1'b1;
    rst_ab_n = 1'b0;
    rst_c_n  = 1'b0;
    step(5);

    // Reset state
    check("rst_drawx",   x_a, 0);
    check("rst_drawy",   y_a, 0);
    check("rst_blank",   blank_a, 0);
    check("rst_hs",      hs_a, 1);
    check("rst_vs",      vs_a, 1);
    check("rst_fcount",  fc_a, 0);
    check("rst_lstart",  ls_a, 0);
    check("rst_fstart",  fs_a, 0);
    check("rst_hs_b",    hs_b, 1);

    // First cycle after release
    rst_ab_n = 1'b1;
    step(1);
    check("rel_drawx",  x_a, 0);
    check("rel_drawy",  y_a, 0);
    check("rel_blank",  blank_a, 1);
    check("rel_lstart", ls_a, 1);
    check("rel_fstart", fs_a, 1);
    check("rel_fcount", fc_a, 0);

    // Line 0 of the 640x480 raster
    blank_cnt = 0; hs_low_a = 0; hs_low_b = 0; vs_low_ab = 0;
    fall_a = -1; rise_a = -1; fall_b = -1; rise_b = -1;
    prev_a = hs_a; prev_b = hs_b;
    for (int i = 0; i < 800; i++) begin
      if (blank_a) blank_cnt++;
      if (!hs_a) hs_low_a++;
      if (!hs_b) hs_low_b++;
      if (!vs_a || !vs_b) vs_low_ab++;
      if (prev_a && !hs_a) fall_a = int'(x_a);
      if (!prev_a && hs_a) rise_a = int'(x_a);
      if (prev_b && !hs_b) fall_b = int'(x_b);
      if (!prev_b && hs_b) rise_b = int'(x_b);
      prev_a = hs_a;
      prev_b = hs_b;
      if (i == 799) begin
        check("eol_drawx",  x_a, 799);
        check("eol_drawy",  y_a, 0);
        check("eol_lstart", ls_a, 0);
      end
      step(1);
    end
    check("wrap_drawx",  x_a, 0);
    check("wrap_drawy",  y_a, 1);
    check("wrap_lstart", ls_a, 1);
    check("wrap_fstart", fs_a, 0);
    check("line_blank_cycles", blank_cnt, 640);
    check("hs_a_low_cycles", hs_low_a, 96);
    check("hs_a_fall_x",     fall_a, 657);
    check("hs_a_rise_x",     rise_a, 753);
    check("hs_b_low_cycles", hs_low_b, 96);
    check("hs_b_fall_x",     fall_b, 656);
    check("hs_b_rise_x",     rise_b, 752);
    check("vs_low_line0",    vs_low_ab, 0);

    // Small raster: two full frames (144 cycles each)
    rst_c_n = 1'b1;
    step(1);
    check("c_rel_blank",  blank_c, 1);
    check("c_rel_fstart", fs_c, 1);
    blank_c_cnt = 0; blank_vbl = 0; vs_low_c = 0; fs_cnt = 0; ls_cnt = 0;
    vs_fall_x = -1; vs_fall_y = -1;
    prev_vs = vs_c;
    for (int i = 0; i < 288; i++) begin
      if (blank_c) blank_c_cnt++;
      if (blank_c && y_c >= 10'd4) blank_vbl++;
      if (!vs_c) vs_low_c++;
      if (fs_c) fs_cnt++;
      if (ls_c) ls_cnt++;
      if (prev_vs && !vs_c && vs_fall_x < 0) begin
        vs_fall_x = int'(x_c);
        vs_fall_y = int'(y_c);
      end
      prev_vs = vs_c;
      if (i == 143) begin
        check("c_last_x",      x_c, 15);
        check("c_last_y",      y_c, 8);
        check("c_last_fcount", fc_c, 0);
      end
      if (i == 144) begin
        check("c_f1_fcount", fc_c, 1);
        check("c_f1_fstart", fs_c, 1);
        check("c_f1_lstart", ls_c, 1);
        check("c_f1_drawy",  y_c, 0);
      end
      step(1);
    end
    check("c_fcount_2",      fc_c, 2);
    check("c_blank_cycles",  blank_c_cnt, 64);
    check("c_blank_in_vbl",  blank_vbl, 0);
    check("c_vs_low_cycles", vs_low_c, 64);
    check("c_vs_fall_x",     vs_fall_x, 2);
    check("c_vs_fall_y",     vs_fall_y, 5);
    check("c_fstart_count",  fs_cnt, 2);
    check("c_lstart_count",  ls_cnt, 18);

    // Mid-frame reset inside hsync (DrawX=12, DrawY=2 of frame 2)
    step(44);
    check("c_pre_rst_x",  x_c, 12);
    check("c_pre_rst_y",  y_c, 2);
    check("c_pre_rst_hs", hs_c, 0);
    rst_c_n = 1'b0;
    step(1);
    check("c_mrst_x",      x_c, 0);
    check("c_mrst_y",      y_c, 0);
    check("c_mrst_hs",     hs_c, 1);
    check("c_mrst_fcount", fc_c, 0);
    rst_c_n = 1'b1;
    step(1);
    check("c_mrel_x",      x_c, 0);
    check("c_mrel_blank",  blank_c, 1);
    check("c_mrel_hs",     hs_c, 1);
    first_hs = -1;
    for (int i = 0; i < 16; i++) begin
      if (!hs_c && first_hs < 0) first_hs = int'(x_c);
      step(1);
    end
    check("c_no_runt_first_hs_x", first_hs, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
